reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 7 +
 rtl/reg_file_sb_sb_cnt.sv | 26 ++
 rtl/reg_file_sb.sv | 98 +++++++++
 tb/tb_reg_file_sb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared widths and constants for the scoreboarded register file
package reg_file_sb_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;
  localparam logic [REG_AW-1:0] X0 = '0;
endpackage

// File: rtl/reg_file_sb_sb_cnt.sv
// rtl/reg_file_sb_sb_cnt.sv - per-register pending-write up/down counter
module sb_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = &cnt;

  // Simultaneous inc and dec cancel; both ends hold rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec && !at_max) begin
      cnt <= cnt + W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 31-entry register file with WB bypass and pending-write scoreboard
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN  = reg_file_sb_pkg::XLEN,
  parameter int CNT_W = reg_file_sb_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write_en_wb,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic [XLEN-1:0]   reg_write_data_wb,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              rs1_used_id,
  input  logic              rs2_used_id,
  input  logic              issue_valid_id,
  input  logic              issue_wr_id,
  input  logic [REG_AW-1:0] issue_rd_id,
  output logic [XLEN-1:0]   rs1_data_id,
  output logic [XLEN-1:0]   rs2_data_id,
  output logic              stall_id,
  output logic              sb_err
);

  logic [XLEN-1:0]  regs [1:31];
  logic [CNT_W-1:0] cnt  [32];
  logic [31:0]      at_max;
  logic [31:1]      inc;
  logic [31:1]      dec;

  logic wb_act, issue_ok;
  logic hit1, hit2, busy1, busy2, rd_full;

  assign wb_act   = reg_write_en_wb && (rd_wb != X0);
  assign cnt[0]   = '0;
  assign at_max[0] = 1'b0;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < 32; r++) begin
      inc[r] = issue_ok && (issue_rd_id == REG_AW'(r));
      dec[r] = wb_act && (rd_wb == REG_AW'(r));
    end
  end

  for (genvar r = 1; r < 32; r++) begin : g_cnt
    sb_cnt #(.W(CNT_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc    (inc[r]),
      .dec    (dec[r]),
      .cnt    (cnt[r]),
      .at_max (at_max[r])
    );
  end

  // Reads: a same-cycle writeback wins over the stored value.
  assign hit1 = wb_act && (rd_wb == rs1_id);
  assign hit2 = wb_act && (rd_wb == rs2_id);

  assign rs1_data_id = hit1 ? reg_write_data_wb :
                       (rs1_id == X0) ? '0 : regs[rs1_id];
  assign rs2_data_id = hit2 ? reg_write_data_wb :
                       (rs2_id == X0) ? '0 : regs[rs2_id];

  // The last outstanding write landing this cycle is covered by the bypass.
  assign busy1 = (rs1_id != X0) && (cnt[rs1_id] != '0) &&
                 !((cnt[rs1_id] == CNT_W'(1)) && hit1);
  assign busy2 = (rs2_id != X0) && (cnt[rs2_id] != '0) &&
                 !((cnt[rs2_id] == CNT_W'(1)) && hit2);

  assign rd_full = issue_wr_id && (issue_rd_id != X0) && at_max[issue_rd_id] &&
                   !(wb_act && (rd_wb == issue_rd_id));

  assign stall_id = issue_valid_id &&
                    ((rs1_used_id && busy1) || (rs2_used_id && busy2) || rd_full);

  assign issue_ok = issue_valid_id && !stall_id && issue_wr_id && (issue_rd_id != X0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < 32; r++) regs[r] <= '0;
    end else if (wb_act) begin
      regs[rd_wb] <= reg_write_data_wb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err <= 1'b0;
    end else if (wb_act && (cnt[rd_wb] == '0)) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb with directed vectors
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reg_write_en_wb;
  logic [4:0]  rd_wb;
  logic [31:0] reg_write_data_wb;
  logic [4:0]  rs1_id, rs2_id;
  logic        rs1_used_id, rs2_used_id;
  logic        issue_valid_id, issue_wr_id;
  logic [4:0]  issue_rd_id;
  logic [31:0] rs1_data_id, rs2_data_id;
  logic        stall_id, sb_err;

  reg_file_sb dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .reg_write_en_wb   (reg_write_en_wb),
    .rd_wb             (rd_wb),
    .reg_write_data_wb (reg_write_data_wb),
    .rs1_id            (rs1_id),
    .rs2_id            (rs2_id),
    .rs1_used_id       (rs1_used_id),
    .rs2_used_id       (rs2_used_id),
    .issue_valid_id    (issue_valid_id),
    .issue_wr_id       (issue_wr_id),
    .issue_rd_id       (issue_rd_id),
    .rs1_data_id       (rs1_data_id),
    .rs2_data_id       (rs2_data_id),
    .stall_id          (stall_id),
    .sb_err            (sb_err)
  );

  always #5 clk = ~clk;

  localparam int K_RS1 = 0, K_RS2 = 1, K_STALL = 2, K_ERR = 3;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] act;
  int          tests  = 0;
  int          failed = 0;
  bit          done   = 1'b0;

  task automatic push_exp(input int kind, input logic [31:0] val, input string name);
    exp_t x;
    x.kind = kind;
    x.val  = val;
    x.name = name;
    q.push_back(x);
  endtask

  task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clr();
    reg_write_en_wb   = 1'b0;
    rd_wb             = '0;
    reg_write_data_wb = '0;
    rs1_id            = '0;
    rs2_id            = '0;
    rs1_used_id       = 1'b0;
    rs2_used_id       = 1'b0;
    issue_valid_id    = 1'b0;
    issue_wr_id       = 1'b0;
    issue_rd_id       = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    reg_write_en_wb   = 1'b1;
    rd_wb             = rd;
    reg_write_data_wb = d;
  endtask

  task automatic issue(input logic wr, input logic [4:0] rd);
    issue_valid_id = 1'b1;
    issue_wr_id    = wr;
    issue_rd_id    = rd;
  endtask

  initial begin
    #100000;
    if (!done) begin
      failed++;
      $display("FAIL timeout: stimulus did not complete");
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
    end
  end

  // Monitor: every expectation queued during a cycle is checked mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      case (e.kind)
        K_RS1:   act = rs1_data_id;
        K_RS2:   act = rs2_data_id;
        K_STALL: act = {31'b0, stall_id};
        default: act = {31'b0, sb_err};
      endcase
      tests++;
      if (act !== e.val) begin
        failed++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    clr();
    #1;
    check_now("reset_now_err", {31'b0, sb_err}, 0);
    check_now("reset_now_stall", {31'b0, stall_id}, 0);
    push_exp(K_STALL, 0, "reset_stall");
    push_exp(K_ERR,   0, "reset_err");
    tick();
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      rs1_id = 5'(i);
      rs2_id = 5'(31 - i);
      push_exp(K_RS1, 0, $sformatf("reset_rs1_x%0d", i));
      push_exp(K_RS2, 0, $sformatf("reset_rs2_x%0d", 31 - i));
      tick();
    end

    clr();
    wb(5'd0, 32'hDEADBEEF);
    push_exp(K_RS1, 0, "x0_no_bypass");
    tick();
    clr();
    push_exp(K_RS1, 0, "x0_after_write");
    push_exp(K_ERR, 0, "x0_write_no_err");
    tick();

    wb(5'd5, 32'h12345678);
    rs1_id = 5'd5;
    push_exp(K_RS1, 32'h12345678, "x5_bypass");
    tick();
    clr();
    rs1_id = 5'd5;
    push_exp(K_RS1, 32'h12345678, "x5_stored");
    push_exp(K_ERR, 1, "x5_underflow_err");
    tick();
    rst_n = 1'b0;
    push_exp(K_ERR, 0, "async_reset_err");
    push_exp(K_RS1, 0, "async_reset_x5");
    tick();
    rst_n = 1'b1;
    clr();

    issue(1'b1, 5'd7);
    push_exp(K_STALL, 0, "issue_x7");
    tick();
    clr();
    issue(1'b0, 5'd0);
    rs2_id = 5'd7; rs2_used_id = 1'b1;
    push_exp(K_STALL, 1, "raw_x7_stall_a");
    tick();
    push_exp(K_STALL, 1, "raw_x7_stall_b");
    tick();
    wb(5'd7, 32'hCAFEF00D);
    push_exp(K_STALL, 0, "raw_x7_wb_stall");
    push_exp(K_RS2, 32'hCAFEF00D, "raw_x7_wb_data");
    tick();
    reg_write_en_wb = 1'b0;
    push_exp(K_STALL, 0, "raw_x7_clear");
    push_exp(K_RS2, 32'hCAFEF00D, "raw_x7_stored");
    push_exp(K_ERR, 0, "raw_x7_no_err");
    tick();
    clr();

    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 5'd9);
      push_exp(K_STALL, 0, $sformatf("x9_issue_%0d", i));
      tick();
    end
    push_exp(K_STALL, 1, "x9_full_stall");
    tick();
    wb(5'd9, 32'h00000099);
    push_exp(K_STALL, 0, "x9_full_with_wb");
    tick();
    clr();
    issue(1'b1, 5'd9);
    push_exp(K_STALL, 1, "x9_still_three");
    tick();
    clr();
    issue(1'b0, 5'd0);
    rs1_id = 5'd9; rs1_used_id = 1'b1;
    wb(5'd9, 32'h000000A1);
    push_exp(K_STALL, 1, "x9_drain_cnt3");
    push_exp(K_RS1, 32'h000000A1, "x9_drain_bypass");
    tick();
    wb(5'd9, 32'h000000A2);
    push_exp(K_STALL, 1, "x9_drain_cnt2");
    tick();
    wb(5'd9, 32'h000000A3);
    push_exp(K_STALL, 0, "x9_drain_cnt1");
    push_exp(K_RS1, 32'h000000A3, "x9_last_bypass");
    tick();
    reg_write_en_wb = 1'b0;
    push_exp(K_STALL, 0, "x9_drained");
    push_exp(K_ERR, 0, "x9_no_err");
    tick();
    clr();

    issue(1'b1, 5'd9);
    push_exp(K_STALL, 0, "x9_pending");
    tick();
    clr();
    wb(5'd3, 32'h00000033);
    push_exp(K_ERR, 0, "x3_err_not_yet");
    tick();
    clr();
    rs1_id = 5'd3;
    issue(1'b0, 5'd0);
    rs2_id = 5'd9; rs2_used_id = 1'b1;
    push_exp(K_ERR, 1, "x3_err_set");
    push_exp(K_RS1, 32'h00000033, "x3_written");
    push_exp(K_STALL, 1, "x9_busy_before_reset");
    tick();
    push_exp(K_ERR, 1, "x3_err_sticky");
    tick();
    rst_n = 1'b0;
    #1;
    check_now("async_reset_err_now", {31'b0, sb_err}, 0);
    check_now("async_reset_cnt_now", {31'b0, stall_id}, 0);
    push_exp(K_ERR, 0, "reset_clears_err");
    push_exp(K_STALL, 0, "reset_clears_cnt");
    push_exp(K_RS1, 0, "reset_clears_x3");
    tick();
    rst_n = 1'b1;
    clr();
    wb(5'd4, 32'h00004444);
    rs2_id = 5'd4;
    push_exp(K_RS2, 32'h00004444, "post_reset_bypass");
    push_exp(K_ERR, 0, "post_reset_err");
    tick();
    clr();
    rs2_id = 5'd4;
    push_exp(K_RS2, 32'h00004444, "post_reset_stored");
    tick();

    @(negedge clk);
    #1;
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
